// File: rtl/slt_pkg.sv
// Shared definitions for the bit-serial set-less-than unit.
//   state_t   : FSM state encoding (IDLE, SIGN, SCAN, DONE)
//   idx_width : width of the bit-index down-counter for a given operand width
package slt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SIGN = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bits needed to index 0..width-1; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned width);
        int unsigned w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/zext_1_to_w.sv
// Zero-extends a single flag bit to a WIDTH-bit word.
//   flag : input bit, lands in word[0]
//   word : {(WIDTH-1) zeros, flag}
module zext_1_to_w #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             flag,
    output logic [WIDTH-1:0] word
);

    assign word = {{(WIDTH-1){1'b0}}, flag};

endmodule

// File: rtl/slt_serial_ctrl.sv
// Multi-cycle set-less-than unit (slt/sltu/slti/sltiu) for low-area cores.
// Scans captured operands MSB to LSB, one bit per cycle, and reports the
// less-than flag zero-extended to WIDTH bits. One operation in flight.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : operand request handshake (a, b, is_signed)
//   out_valid/out_ready  : result handshake (result)
//   busy                 : an operation is in SIGN, SCAN or DONE
module slt_serial_ctrl
    import slt_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned    IW        = idx_width(WIDTH);
    localparam int unsigned    MSB       = WIDTH - 1;
    localparam logic [IW-1:0]  IDX_START = IW'(WIDTH - 2);

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             signed_r;
    logic [IW-1:0]    idx;
    logic             lt;
    logic             found;

    // Current scan bit pair.
    logic             a_bit;
    logic             b_bit;
    logic             bit_diff;

    assign a_bit    = a_r[idx];
    assign b_bit    = b_r[idx];
    assign bit_diff = a_bit ^ b_bit;

    // Control FSM, operand registers, index counter and lt flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            signed_r  <= 1'b0;
            idx       <= '0;
            lt        <= 1'b0;
            found     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b;
                        signed_r <= is_signed;
                        lt       <= 1'b0;
                        found    <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_SIGN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end

                // Differing MSBs decide the result on their own; which operand
                // wins depends on whether the MSB is a sign bit.
                ST_SIGN: begin
                    if (a_r[MSB] != b_r[MSB]) begin
                        lt    <= signed_r ? a_r[MSB] : b_r[MSB];
                        found <= 1'b1;
                        if (EARLY_EXIT) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= IDX_START;
                            state <= ST_SCAN;
                        end
                    end else begin
                        idx   <= IDX_START;
                        state <= ST_SCAN;
                    end
                end

                // MSBs matched (or already decided): below the MSB the operand
                // with the 1 at the first differing bit is the larger one.
                ST_SCAN: begin
                    if (!found && bit_diff) begin
                        lt    <= b_bit;
                        found <= 1'b1;
                    end
                    if ((EARLY_EXIT && bit_diff) || (idx == '0)) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end

                // out_valid rises one cycle after entering DONE and holds
                // until the consumer takes the result.
                ST_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    zext_1_to_w #(
        .WIDTH (WIDTH)
    ) u_zext (
        .flag (lt),
        .word (result)
    );

endmodule

// File: tb/tb_slt_serial_ctrl.sv
// Self-checking bench for slt_serial_ctrl: one early-exit instance and one
// fixed-latency instance sharing operand inputs; sel picks the active one.
module tb_slt_serial_ctrl;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         is_signed;
    logic         sel;

    logic         in_valid_e, in_ready_e, out_valid_e, busy_e;
    logic         in_valid_f, in_ready_f, out_valid_f, busy_f;
    logic [W-1:0] result_e, result_f;

    logic         in_ready_m, out_valid_m, busy_m;
    logic [W-1:0] result_m;

    int n_cmp = 0;
    int n_err = 0;

    logic exp_res_q[$];
    int   exp_lat_q[$];

    always #5 clk = ~clk;

    assign in_valid_e  = in_valid & ~sel;
    assign in_valid_f  = in_valid & sel;
    assign in_ready_m  = sel ? in_ready_f  : in_ready_e;
    assign out_valid_m = sel ? out_valid_f : out_valid_e;
    assign busy_m      = sel ? busy_f      : busy_e;
    assign result_m    = sel ? result_f    : result_e;

    slt_serial_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_e (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_e),
        .in_ready  (in_ready_e),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid_e),
        .out_ready (out_ready),
        .result    (result_e),
        .busy      (busy_e)
    );

    slt_serial_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_f (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_f),
        .in_ready  (in_ready_f),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid_f),
        .out_ready (out_ready),
        .result    (result_f),
        .busy      (busy_f)
    );

    // Drive a request through its accept edge; returns at the negedge after it.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic ts, input logic tsel,
                            input logic exp_res, input int exp_lat, input bit push,
                            input string name);
        int n;
        if (push) begin
            exp_res_q.push_back(exp_res);
            exp_lat_q.push_back(exp_lat);
        end
        @(negedge clk);
        sel       = tsel;
        a         = ta;
        b         = tb_v;
        is_signed = ts;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!in_ready_m) begin
            n_err++;
            $display("FAIL %s accept: in_ready=%b required 1", name, in_ready_m);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        // Scrambled ports must not disturb the captured operands.
        a         = $urandom;
        b         = $urandom;
        is_signed = ~ts;
    endtask

    // From the negedge after the accept edge: measure latency, pop, compare.
    task automatic collect(input string name);
        int   lat;
        logic er;
        int   el;
        lat = 0;
        while (!out_valid_m && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (exp_res_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s scoreboard: queue empty", name);
            return;
        end
        er = exp_res_q.pop_front();
        el = exp_lat_q.pop_front();
        n_cmp++;
        if (lat != el) begin
            n_err++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, el);
        end
        n_cmp++;
        if (result_m !== W'(er)) begin
            n_err++;
            $display("FAIL %s result: got %h required %h", name, result_m, W'(er));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid_m !== 1'b0) begin
            n_err++;
            $display("FAIL %s out_valid_drop: got %b required 0", name, out_valid_m);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, input logic tsel,
                          input logic exp_res, input int exp_lat, input string name);
        start_op(ta, tb_v, ts, tsel, exp_res, exp_lat, 1'b1, name);
        collect(name);
    endtask

    task automatic test_reset();
        @(negedge clk);
        sel      = 1'b0;
        reset    = 1'b1;
        in_valid = 1'b1;
        a        = 32'h0000_0001;
        b        = 32'h0000_0002;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready_m !== 1'b0) begin
                n_err++;
                $display("FAIL reset_in_ready: got %b required 0", in_ready_m);
            end
            n_cmp++;
            if (out_valid_m !== 1'b0) begin
                n_err++;
                $display("FAIL reset_out_valid: got %b required 0", out_valid_m);
            end
            n_cmp++;
            if (result_m !== '0) begin
                n_err++;
                $display("FAIL reset_result: got %h required 0", result_m);
            end
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy_m !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_accept: busy=%b required 0", busy_m);
        end
        @(negedge clk);
        n_cmp++;
        if (in_ready_m !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle_ready: got %b required 1", in_ready_m);
        end
    endtask

    task automatic test_msb_differs();
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 2, "msb_signed");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 2, "msb_unsigned");
        run_op(32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 2, "msb_signed_pos");
    endtask

    task automatic test_scan();
        run_op(32'h0000_0004, 32'h0000_0006, 1'b0, 1'b0, 1'b1, 32, "bit1_unsigned");
        run_op(32'h4000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 3, "bit30_signed");
        run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 33, "bit0_signed");
    endtask

    task automatic test_equal();
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 33, "equal_signed");
        run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 33, "equal_unsigned");
    endtask

    task automatic test_fixed_latency();
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 33, "fixed_msb_signed");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 33, "fixed_msb_unsigned");
        run_op(32'h0000_0004, 32'h0000_0006, 1'b0, 1'b1, 1'b1, 33, "fixed_bit1");
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b0;
        // 0x10 < 0x20, first difference at bit 5.
        start_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b1, 28, 1'b1, "stall");
        lat = 0;
        while (!out_valid_m && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        // Second request (7 vs 2 signed -> 0, difference at bit 2) waits.
        exp_res_q.push_back(1'b0);
        exp_lat_q.push_back(31);
        a         = 32'h0000_0007;
        b         = 32'h0000_0002;
        is_signed = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid_m !== 1'b1 || result_m !== 32'h1) begin
                n_err++;
                $display("FAIL stall_hold: out_valid=%b result=%h required 1/00000001",
                         out_valid_m, result_m);
            end
            n_cmp++;
            if (in_ready_m !== 1'b0) begin
                n_err++;
                $display("FAIL stall_in_ready: got %b required 0", in_ready_m);
            end
        end
        if (exp_res_q.size() > 0) begin
            void'(exp_res_q.pop_front());
            void'(exp_lat_q.pop_front());
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1 || busy_m !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: out_valid=%b in_ready=%b busy=%b required 0/1/0",
                     out_valid_m, in_ready_m, busy_m);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        n_cmp++;
        if (busy_m !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: busy=%b required 1", busy_m);
        end
        collect("b2b_second");
    endtask

    task automatic test_reset_mid_op();
        int seen;
        start_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 0, 1'b0, "abort");
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy_m !== 1'b1) begin
            n_err++;
            $display("FAIL abort_busy: got %b required 1", busy_m);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (busy_m !== 1'b0 || out_valid_m !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: busy=%b out_valid=%b required 0/0", busy_m, out_valid_m);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid_m) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL abort_no_output: out_valid cycles=%0d required 0", seen);
        end
        run_op(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 31, "after_abort");
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        sel       = 1'b0;
        test_reset();
        test_msb_differs();
        test_scan();
        test_equal();
        test_fixed_latency();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
